// File: rtl/conv_window_scheduler.sv
// Batch sequencer for a valid-mode 2-D convolution on tensor_processing_unit.
// Packs row-major output pixels into NUM_UNITS lanes, runs the TPU, commits ReLU results.
module conv_window_scheduler #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 5,
  parameter int unsigned IMAGE_HEIGHT = 5,
  parameter int unsigned NUM_UNITS    = 9,
  parameter int unsigned MEM_SIZE     = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int unsigned AW = $clog2(MEM_SIZE),
  localparam int unsigned KW = $clog2(IMAGE_WIDTH),
  localparam int unsigned LW = $clog2(MEM_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  input  logic [KW-1:0]                    cmd_kernel_dim,
  output logic                             cmd_ready,
  output logic                             cmd_error,
  output logic                             busy,
  output logic                             conv_done,
  output logic [KW-1:0]                    tpu_kernel_dim,
  output logic [LW-1:0]                    tpu_length,
  output logic [NUM_UNITS*AW-1:0]          tpu_start_addr_1,
  output logic [NUM_UNITS*AW-1:0]          tpu_start_addr_2,
  output logic [NUM_UNITS-1:0]             tpu_active_units,
  output logic                             tpu_read_mem1,
  output logic                             tpu_read_mem2,
  output logic                             tpu_simple_read,
  output logic                             tpu_start,
  input  logic                             tpu_done,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]  tpu_relu_out,
  output logic                             simple_write,
  output logic [NUM_UNITS-1:0]             simple_write_mask,
  output logic [NUM_UNITS*AW-1:0]          simple_write_addr,
  output logic [NUM_UNITS*DATA_WIDTH-1:0]  simple_write_data
);

  localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_WRITE,
    S_FIN
  } state_t;

  state_t                                 state_q;
  logic [KW-1:0]                          k_q;
  logic [LW-1:0]                          len_q;
  logic [LW-1:0]                          ow_q;
  logic [LW-1:0]                          total_q;
  logic [LW-1:0]                          n_q;
  logic [LW-1:0]                          col_q;
  logic [AW-1:0]                          rbase_q;
  logic [UW-1:0]                          lane_q;
  logic                                   rd_en_q;
  logic [NUM_UNITS-1:0]                   mask_q;
  logic [NUM_UNITS-1:0][AW-1:0]           win_q;
  logic [NUM_UNITS-1:0][AW-1:0]           waddr_q;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   data_q;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   relu_lanes;

  logic          k_bad_c;
  logic [LW-1:0] ow_c;
  logic [LW-1:0] oh_c;
  logic [LW-1:0] total_c;
  logic [LW-1:0] len_c;
  logic [AW-1:0] win_addr_c;
  logic          last_col_c;
  logic          last_lane_c;
  logic          last_pix_c;

  assign relu_lanes = tpu_relu_out;

  // Command decode and iterator helpers; no division, only the running row base.
  always_comb begin
    k_bad_c     = (cmd_kernel_dim == '0) ||
                  (32'(cmd_kernel_dim) > IMAGE_WIDTH) ||
                  (32'(cmd_kernel_dim) > IMAGE_HEIGHT);
    ow_c        = LW'(IMAGE_WIDTH - 32'(cmd_kernel_dim) + 32'd1);
    oh_c        = LW'(IMAGE_HEIGHT - 32'(cmd_kernel_dim) + 32'd1);
    total_c     = LW'(32'(ow_c) * 32'(oh_c));
    len_c       = LW'(32'(cmd_kernel_dim) * 32'(cmd_kernel_dim));
    win_addr_c  = AW'(32'(rbase_q) + 32'(col_q));
    last_col_c  = (col_q == ow_q - LW'(1));
    last_lane_c = (32'(lane_q) == NUM_UNITS - 1);
    last_pix_c  = (n_q == total_q - LW'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      len_q        <= '0;
      ow_q         <= '0;
      total_q      <= '0;
      n_q          <= '0;
      col_q        <= '0;
      rbase_q      <= '0;
      lane_q       <= '0;
      rd_en_q      <= 1'b0;
      mask_q       <= '0;
      win_q        <= '0;
      waddr_q      <= '0;
      data_q       <= '0;
      cmd_ready    <= 1'b1;
      cmd_error    <= 1'b0;
      busy         <= 1'b0;
      conv_done    <= 1'b0;
      tpu_start    <= 1'b0;
      simple_write <= 1'b0;
    end else begin
      cmd_error <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (k_bad_c) begin
              cmd_error <= 1'b1;
            end else begin
              k_q       <= cmd_kernel_dim;
              len_q     <= len_c;
              ow_q      <= ow_c;
              total_q   <= total_c;
              n_q       <= '0;
              col_q     <= '0;
              rbase_q   <= '0;
              lane_q    <= '0;
              mask_q    <= '0;
              win_q     <= '0;
              waddr_q   <= '0;
              data_q    <= '0;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              state_q   <= S_LOAD;
            end
          end
        end

        // One lane per cycle, then step the (row, col) iterator.
        S_LOAD: begin
          win_q[lane_q]   <= win_addr_c;
          waddr_q[lane_q] <= AW'(n_q);
          mask_q[lane_q]  <= 1'b1;
          n_q             <= n_q + LW'(1);
          if (last_col_c) begin
            col_q   <= '0;
            rbase_q <= AW'(32'(rbase_q) + IMAGE_WIDTH);
          end else begin
            col_q <= col_q + LW'(1);
          end
          if (last_lane_c || last_pix_c) begin
            lane_q  <= '0;
            rd_en_q <= 1'b1;
            state_q <= S_ARM;
          end else begin
            lane_q <= lane_q + UW'(1);
          end
        end

        S_ARM: begin
          tpu_start <= 1'b1;
          state_q   <= S_RUN;
        end

        // Inactive lanes are forced to zero regardless of what the TPU drives.
        S_RUN: begin
          if (tpu_done) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
              data_q[i] <= mask_q[i] ? relu_lanes[i] : '0;
            end
            tpu_start    <= 1'b0;
            rd_en_q      <= 1'b0;
            simple_write <= 1'b1;
            state_q      <= S_WRITE;
          end
        end

        S_WRITE: begin
          simple_write <= 1'b0;
          if (n_q < total_q) begin
            mask_q  <= '0;
            win_q   <= '0;
            waddr_q <= '0;
            data_q  <= '0;
            state_q <= S_LOAD;
          end else begin
            conv_done <= 1'b1;
            state_q   <= S_FIN;
          end
        end

        S_FIN: begin
          conv_done <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state_q   <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tpu_kernel_dim    = k_q;
  assign tpu_length        = len_q;
  assign tpu_start_addr_1  = win_q;
  assign tpu_start_addr_2  = '0;
  assign tpu_active_units  = mask_q;
  assign tpu_read_mem1     = rd_en_q;
  assign tpu_read_mem2     = rd_en_q;
  assign tpu_simple_read   = rd_en_q;
  assign simple_write_mask = mask_q;
  assign simple_write_addr = waddr_q;
  assign simple_write_data = data_q;

endmodule
